// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Access-size encodings, FSM states and alignment check for dmem.
// Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Illegal sizes count as misaligned so they share the error path.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : dmem_load_extend
// Brief    : Selects the addressed byte/half from a word and sign/zero extends.
// Revision : 1.0  initial release
// ============================================================================
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] lanes_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] w_shifted;

    assign w_shifted = lanes_i >> {addr_lo_i, 3'b000};

    always_comb begin
        result_o = 32'd0;
        case (size_i)
            SZ_BYTE: result_o = unsigned_i ? {24'd0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: result_o = unsigned_i ? {16'd0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
            SZ_WORD: result_o = lanes_i;
            default: result_o = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_sized_access.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sized_access
// Brief    : Multi-cycle little-endian byte-addressed data memory, sized access.
// Revision : 1.0  initial release
// ============================================================================
module dmem_sized_access
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic        resp_valid,
    output logic [31:0] readData,
    output logic        misaligned_err
);

    logic [7:0] mem [0:2**ADDR_BITS-1];

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [1:0]             size_q;
    logic                   uns_q;
    logic                   write_q;
    logic [31:0]            wdata_q;
    logic                   resp_valid_q;
    logic [31:0]            rdata_q;
    logic                   err_q;

    logic [31:0]            w_lanes;
    logic [31:0]            w_load;
    logic [31:0]            w_wlanes;
    logic [3:0]             w_be;
    logic                   w_commit;
    logic                   w_we;
    logic                   w_addr_unused;

    assign w_addr_unused = ^address[31:ADDR_BITS];

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = resp_valid_q;
    assign readData       = rdata_q;
    assign misaligned_err = err_q;

    assign w_commit = (state_q == WAIT) && (cnt_q == 4'd0);
    assign w_we     = w_commit && write_q && !rst;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign w_lanes[8*k +: 8] = mem[{addr_q[ADDR_BITS-1:2], 2'(k)}];
    end

    dmem_load_extend u_extend (
        .lanes_i    (w_lanes),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (w_load)
    );

    // Replicate store data across lanes so each enabled byte picks its own slice.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                w_be     = 4'b0001 << addr_q[1:0];
                w_wlanes = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                w_be     = 4'b0011 << addr_q[1:0];
                w_wlanes = {2{wdata_q[15:0]}};
            end
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    mem[{addr_q[ADDR_BITS-1:2], k[1:0]}] <= w_wlanes[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= address[ADDR_BITS-1:0];
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        write_q <= req_write;
                        wdata_q <= writeData;
                        if (is_misaligned(req_size, address[1:0])) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            err_q        <= 1'b1;
                            rdata_q      <= 32'd0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        err_q        <= 1'b0;
                        rdata_q      <= write_q ? 32'd0 : w_load;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_sized_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_sized_access
// Brief    : Directed vector bench: two instances (WAIT_STATES=2 and 0).
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_sized_access;
    import dmem_pkg::*;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid      [2];
    logic        req_ready      [2];
    logic        req_write      [2];
    logic [1:0]  req_size       [2];
    logic        req_unsigned   [2];
    logic [31:0] address        [2];
    logic [31:0] writeData      [2];
    logic        resp_valid     [2];
    logic [31:0] readData       [2];
    logic        misaligned_err [2];

    int n_pass  = 0;
    int n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_sized_access #(.ADDR_BITS(12), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .address(address[0]),
        .writeData(writeData[0]), .resp_valid(resp_valid[0]),
        .readData(readData[0]), .misaligned_err(misaligned_err[0])
    );

    dmem_sized_access #(.ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .address(address[1]),
        .writeData(writeData[1]), .resp_valid(resp_valid[1]),
        .readData(readData[1]), .misaligned_err(misaligned_err[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic do_req(input int s, input vec_t v, input string nm);
        int wt;
        int lat;
        int ws;
        ws = (s == 0) ? 2 : 0;
        wt = 0;
        @(negedge clk);
        while (!req_ready[s] && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        if (wt >= 100) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
        req_valid[s]    = 1'b1;
        req_write[s]    = v.wr;
        req_size[s]     = v.sz;
        req_unsigned[s] = v.uns;
        address[s]      = v.addr;
        writeData[s]    = v.wdata;
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        lat = 1;
        while (!resp_valid[s] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), v.exp_err ? 32'd1 : 32'(ws + 2));
        chk({nm, "_readData"}, readData[s], v.exp_rd);
        chk({nm, "_err"}, {31'd0, misaligned_err[s]}, {31'd0, v.exp_err});
        @(posedge clk);
        #1;
        chk({nm, "_pulse"}, {31'd0, resp_valid[s]}, 32'd0);
    endtask

    vec_t tbl [21];

    initial begin
        int seen;

        tbl[0]  = mk(1, SZ_WORD, 0, 32'h010, 32'h8899AABB, 32'h0, 0);
        tbl[1]  = mk(0, SZ_WORD, 0, 32'h010, 32'h0, 32'h8899AABB, 0);
        tbl[2]  = mk(0, SZ_BYTE, 0, 32'h010, 32'h0, 32'hFFFFFFBB, 0);
        tbl[3]  = mk(0, SZ_BYTE, 1, 32'h013, 32'h0, 32'h00000088, 0);
        tbl[4]  = mk(0, SZ_HALF, 0, 32'h012, 32'h0, 32'hFFFF8899, 0);
        tbl[5]  = mk(0, SZ_HALF, 1, 32'h010, 32'h0, 32'h0000AABB, 0);
        tbl[6]  = mk(1, SZ_BYTE, 0, 32'h011, 32'hFFFFFF5A, 32'h0, 0);
        tbl[7]  = mk(0, SZ_WORD, 0, 32'h010, 32'h0, 32'h88995ABB, 0);
        tbl[8]  = mk(0, SZ_BYTE, 0, 32'h011, 32'h0, 32'h0000005A, 0);
        tbl[9]  = mk(0, SZ_HALF, 1, 32'h012, 32'h0, 32'h00008899, 0);
        tbl[10] = mk(1, SZ_WORD, 0, 32'h000, 32'h11223344, 32'h0, 0);
        tbl[11] = mk(0, SZ_WORD, 0, 32'h000, 32'h0, 32'h11223344, 0);
        tbl[12] = mk(0, SZ_WORD, 0, 32'h012, 32'h0, 32'h0, 1);
        tbl[13] = mk(1, SZ_HALF, 0, 32'h001, 32'h0000BEEF, 32'h0, 1);
        tbl[14] = mk(1, SZ_ILLEGAL, 0, 32'h000, 32'hDEADBEEF, 32'h0, 1);
        tbl[15] = mk(0, SZ_WORD, 0, 32'h000, 32'h0, 32'h11223344, 0);
        tbl[16] = mk(0, SZ_WORD, 0, 32'hFFFFF010, 32'h0, 32'h88995ABB, 0);
        tbl[17] = mk(1, SZ_HALF, 0, 32'h012, 32'hFFFF1234, 32'h0, 0);
        tbl[18] = mk(0, SZ_WORD, 0, 32'h010, 32'h0, 32'h12345ABB, 0);
        tbl[19] = mk(1, SZ_WORD, 0, 32'h020, 32'hA5A5A5A5, 32'h0, 0);
        tbl[20] = mk(0, SZ_WORD, 0, 32'h020, 32'h0, 32'hA5A5A5A5, 0);

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_write[s] = 1'b0; req_size[s] = 2'b00;
            req_unsigned[s] = 1'b0; address[s] = 32'd0; writeData[s] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset_ready%0d", s), {31'd0, req_ready[s]}, 32'd1);
            chk($sformatf("reset_resp%0d", s), {31'd0, resp_valid[s]}, 32'd0);
            chk($sformatf("reset_rdata%0d", s), readData[s], 32'd0);
            chk($sformatf("reset_err%0d", s), {31'd0, misaligned_err[s]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) do_req(0, tbl[i], $sformatf("vec%0d", i));

        // Abort a store by asserting rst in its commit cycle.
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = SZ_WORD;
        req_unsigned[0] = 1'b0; address[0] = 32'h020; writeData[0] = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_resp", {31'd0, resp_valid[0]}, 32'd0);
        chk("abort_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("abort_rdata", readData[0], 32'd0);
        chk("abort_err", {31'd0, misaligned_err[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (resp_valid[0]) seen++;
        end
        chk("abort_no_resp", 32'(seen), 32'd0);
        do_req(0, mk(0, SZ_WORD, 0, 32'h020, 32'h0, 32'hA5A5A5A5, 0), "abort_readback");

        do_req(1, mk(1, SZ_WORD, 0, 32'h1FFC, 32'hCAFEF00D, 32'h0, 0), "wrap_sw");
        do_req(1, mk(0, SZ_WORD, 0, 32'h0FFC, 32'h0, 32'hCAFEF00D, 0), "wrap_lw");
        do_req(1, mk(0, SZ_BYTE, 0, 32'h0FFF, 32'h0, 32'hFFFFFFCA, 0), "wrap_lb");
        do_req(1, mk(0, SZ_HALF, 0, 32'h0FFD, 32'h0, 32'h0, 1), "ws0_err");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
